// File: rtl/pool_layer_2.sv
// ---------------------------------------------------------------------------
// pool_layer_2
//   Streaming 2x2 / stride-2 max-pool stage that sits behind the second
//   convolution layer. One pixel position (all channels side by side) arrives
//   per beat in raster order. One pooled beat is produced for every 2x2
//   window, on a valid/ready stream towards the fully connected stage.
//
//   Optional feature macro: POOL_LAYER_2_RELU_EN
//     When defined, each pooled channel is clamped to max(result, 0) before
//     it is registered. When undefined, the raw signed maximum is output.
//
// Parameters
//   BITWIDTH  signed sample width per channel
//   IN_DIM    input rows/columns (even); the output is IN_DIM/2 square
//   CHANNELS  channels carried side by side in each beat
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   stage can accept a beat
//   in_data    channel c at [c*BITWIDTH +: BITWIDTH]
//   out_valid  pooled beat valid
//   out_ready  downstream accepts
//   out_data   pooled samples, same packing as in_data
//   out_last   high with the final pooled beat of a frame
// ---------------------------------------------------------------------------
module pool_layer_2 #(
  parameter int BITWIDTH = 16,
  parameter int IN_DIM   = 10,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BITWIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*BITWIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int HALF = IN_DIM / 2;
  localparam int CW   = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(IN_DIM - 1);

  localparam logic [0:0] ROW_EVEN = 1'b0;
  localparam logic [0:0] ROW_ODD  = 1'b1;

  logic [CW-1:0]                r_col;
  logic [CW-1:0]                r_row;
  logic [0:0]                   r_state;
  logic signed [BITWIDTH-1:0]   r_hold    [CHANNELS];
  logic signed [BITWIDTH-1:0]   r_linebuf [CHANNELS][HALF];
  logic                         r_outValid;
  logic [CHANNELS*BITWIDTH-1:0] r_outData;
  logic                         r_outLast;

  logic                         w_accept;
  logic                         w_load;
  logic                         w_colLast;
  logic [HW-1:0]                w_lbIdx;
  logic signed [BITWIDTH-1:0]   w_pix      [CHANNELS];
  logic signed [BITWIDTH-1:0]   w_maxHold  [CHANNELS];
  logic signed [BITWIDTH-1:0]   w_maxLine  [CHANNELS];
  logic signed [BITWIDTH-1:0]   w_result   [CHANNELS];

  // The single output register is the only buffering, so every input beat
  // (not just window-completing ones) stalls while it is full and blocked.
  assign in_ready  = !r_outValid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_colLast = (r_col == LAST_POS);
  assign w_lbIdx   = HW'(r_col >> 1);
  assign w_load    = w_accept && (r_state == ROW_ODD) && r_col[0];

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_last  = r_outLast;

  // Per-channel signed compares: current pixel against the horizontal
  // partial (hold) and against the previous row's pair maximum (linebuf).
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_pix[c]     = $signed(in_data[c*BITWIDTH +: BITWIDTH]);
      w_maxHold[c] = (w_pix[c] > r_hold[c]) ? w_pix[c] : r_hold[c];
      w_maxLine[c] = (w_pix[c] > r_linebuf[c][w_lbIdx]) ? w_pix[c]
                                                         : r_linebuf[c][w_lbIdx];
`ifdef POOL_LAYER_2_RELU_EN
      w_result[c]  = (w_maxHold[c] < 0) ? '0 : w_maxHold[c];
`else
      w_result[c]  = w_maxHold[c];
`endif
    end
  end

  // Position counters, row-phase FSM and window accumulation. On even rows
  // each column pair collapses into linebuf; on odd rows the stored pair is
  // folded in at the even column and the window completes at the odd one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_state <= ROW_EVEN;
      for (int c = 0; c < CHANNELS; c++) begin
        r_hold[c] <= '0;
        for (int k = 0; k < HALF; k++) begin
          r_linebuf[c][k] <= '0;
        end
      end
    end else if (w_accept) begin
      if (w_colLast) begin
        r_col   <= '0;
        r_row   <= (r_row == LAST_POS) ? '0 : r_row + CW'(1);
        r_state <= ~r_state;
      end else begin
        r_col <= r_col + CW'(1);
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_state == ROW_EVEN) begin
          if (!r_col[0]) begin
            r_hold[c] <= w_pix[c];
          end else begin
            r_linebuf[c][w_lbIdx] <= w_maxHold[c];
          end
        end else if (!r_col[0]) begin
          r_hold[c] <= w_maxLine[c];
        end
      end
    end
  end

  // Output register: a new result always wins; otherwise a take empties it.
  // Data and last are left untouched when nothing loads so they stay steady
  // under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outLast  <= 1'b0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_outLast  <= (r_row == LAST_POS) && w_colLast;
      for (int c = 0; c < CHANNELS; c++) begin
        r_outData[c*BITWIDTH +: BITWIDTH] <= w_result[c];
      end
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule
